// File: rtl/fp_div_unit.sv
// Iterative IEEE-754 single-precision divider producing a truncated quotient plus guard/round/sticky.
// Define FP_DIV_RADIX4_EN to retire two quotient bits per DIVIDE cycle instead of one.
module fp_div_unit #(
    parameter int BIAS    = 127,
    parameter int Q_WIDTH = 26
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clk_en_i,
    input  logic        valid_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] to_round_unit_o,
    output logic [2:0]  grs_o,
    output logic        valid_o,
    output logic        fu_state_o,
    output logic        overflow_o,
    output logic        underflow_o,
    output logic        invalid_op_o,
    output logic        div_by_zero_o
);

    localparam logic FU_FREE = 1'b0;
    localparam logic FU_BUSY = 1'b1;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic signed [9:0] BIAS_S = 10'(BIAS);
`ifdef FP_DIV_RADIX4_EN
    localparam int STEP_BITS = 2;
`else
    localparam int STEP_BITS = 1;
`endif
    localparam logic [4:0] LAST_CNT = 5'(Q_WIDTH / STEP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_PREPARE, S_DIVIDE, S_NORMALIZE, S_VALID} state_e;

    state_e state, state_nx;
    logic [4:0] cnt;

    logic [31:0] op_a, op_b;
    logic [23:0] man_b;
    logic [24:0] rem;
    logic [Q_WIDTH-1:0] quo;
    logic signed [9:0] exp_q;
    logic sign_q;

    // One restoring step: {quotient bit, shifted partial remainder}.
    function automatic logic [25:0] div_step(input logic [24:0] r, input logic [23:0] d);
        logic        ge;
        logic [24:0] diff;
        ge   = (r >= {1'b0, d});
        diff = ge ? (r - {1'b0, d}) : r;
        return {ge, diff[23:0], 1'b0};
    endfunction

    // Exponent range saturation: {result, grs, overflow, underflow}.
    function automatic logic [36:0] pack_result(input logic s, input logic signed [9:0] e,
                                                input logic [22:0] m, input logic [2:0] grs);
        if (e >= 10'sd255)
            return {s, 8'hFF, 23'd0, 3'b000, 2'b10};
        else if (e <= 10'sd0)
            return {s, 31'd0, 3'b000, 2'b01};
        else
            return {s, e[7:0], m, grs, 2'b00};
    endfunction

    // Operand classification; denormals behave as zero.
    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_frac, b_frac;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan, res_sign;
    logic signed [9:0] exp_calc;

    assign a_exp    = op_a[30:23];
    assign b_exp    = op_b[30:23];
    assign a_frac   = op_a[22:0];
    assign b_frac   = op_b[22:0];
    assign a_zero   = (a_exp == 8'h00);
    assign b_zero   = (b_exp == 8'h00);
    assign a_inf    = (a_exp == 8'hFF) && (a_frac == 23'd0);
    assign b_inf    = (b_exp == 8'hFF) && (b_frac == 23'd0);
    assign a_nan    = (a_exp == 8'hFF) && (a_frac != 23'd0);
    assign b_nan    = (b_exp == 8'hFF) && (b_frac != 23'd0);
    assign a_snan   = a_nan && !a_frac[22];
    assign b_snan   = b_nan && !b_frac[22];
    assign res_sign = op_a[31] ^ op_b[31];
    assign exp_calc = $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS_S;

    logic        spec_hit;
    logic [31:0] spec_res;
    logic [3:0]  spec_flags;

    always_comb begin
        spec_hit   = 1'b0;
        spec_res   = 32'd0;
        spec_flags = 4'b0000;
        if (a_nan || b_nan) begin
            spec_hit      = 1'b1;
            spec_res      = QNAN;
            spec_flags[1] = a_snan || b_snan;
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_hit      = 1'b1;
            spec_res      = QNAN;
            spec_flags[1] = 1'b1;
        end else if (a_inf) begin
            spec_hit = 1'b1;
            spec_res = {res_sign, 8'hFF, 23'd0};
        end else if (b_zero) begin
            spec_hit      = 1'b1;
            spec_res      = {res_sign, 8'hFF, 23'd0};
            spec_flags[0] = 1'b1;
        end else if (b_inf || a_zero) begin
            spec_hit = 1'b1;
            spec_res = {res_sign, 31'd0};
        end
    end

    // Divide stage: restoring steps against the latched divisor mantissa.
    logic [25:0] step1;
    assign step1 = div_step(rem, man_b);
`ifdef FP_DIV_RADIX4_EN
    logic [25:0] step2;
    assign step2 = div_step(step1[24:0], man_b);
`endif

    // Normalize stage: step1 here supplies the 27th quotient bit when q[25] is clear.
    logic [22:0] norm_man;
    logic        norm_g, norm_r, norm_s;
    logic signed [9:0] norm_exp;
    logic [31:0] norm_res;
    logic [2:0]  norm_grs;
    logic        norm_ovf, norm_unf;

    always_comb begin
        if (quo[Q_WIDTH-1]) begin
            norm_man = quo[Q_WIDTH-2:2];
            norm_g   = quo[1];
            norm_r   = quo[0];
            norm_s   = |rem;
            norm_exp = exp_q;
        end else begin
            norm_man = quo[Q_WIDTH-3:1];
            norm_g   = quo[0];
            norm_r   = step1[25];
            norm_s   = |step1[24:0];
            norm_exp = exp_q - 10'sd1;
        end
    end

    assign {norm_res, norm_grs, norm_ovf, norm_unf} =
        pack_result(sign_q, norm_exp, norm_man, {norm_g, norm_r, norm_s});

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= S_IDLE;
        else if (clk_en_i)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:      if (valid_i) state_nx = S_PREPARE;
            S_PREPARE:   state_nx = spec_hit ? S_VALID : S_DIVIDE;
            S_DIVIDE:    if (cnt == LAST_CNT) state_nx = S_NORMALIZE;
            S_NORMALIZE: state_nx = S_VALID;
            S_VALID:     state_nx = S_IDLE;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt <= 5'd0;
        else if (clk_en_i)
            cnt <= (state == S_DIVIDE) ? cnt + 5'd1 : 5'd0;
    end

    always_ff @(posedge clk_i) begin
        if (clk_en_i) begin
            case (state)
                S_IDLE: begin
                    if (valid_i) begin
                        op_a <= dividend_i;
                        op_b <= divisor_i;
                    end
                end
                S_PREPARE: begin
                    man_b  <= {1'b1, b_frac};
                    rem    <= {2'b01, a_frac};
                    exp_q  <= exp_calc;
                    sign_q <= res_sign;
                    quo    <= '0;
                end
                S_DIVIDE: begin
`ifdef FP_DIV_RADIX4_EN
                    quo <= {quo[Q_WIDTH-3:0], step1[25], step2[25]};
                    rem <= step2[24:0];
`else
                    quo <= {quo[Q_WIDTH-2:0], step1[25]};
                    rem <= step1[24:0];
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            to_round_unit_o <= 32'd0;
            grs_o           <= 3'b000;
            overflow_o      <= 1'b0;
            underflow_o     <= 1'b0;
            invalid_op_o    <= 1'b0;
            div_by_zero_o   <= 1'b0;
        end else if (clk_en_i) begin
            if (state == S_PREPARE && spec_hit) begin
                to_round_unit_o <= spec_res;
                grs_o           <= 3'b000;
                {overflow_o, underflow_o, invalid_op_o, div_by_zero_o} <= spec_flags;
            end else if (state == S_NORMALIZE) begin
                to_round_unit_o <= norm_res;
                grs_o           <= norm_grs;
                overflow_o      <= norm_ovf;
                underflow_o     <= norm_unf;
                invalid_op_o    <= 1'b0;
                div_by_zero_o   <= 1'b0;
            end
        end
    end

    assign valid_o    = (state == S_VALID);
    assign fu_state_o = (state == S_IDLE) ? FU_FREE : FU_BUSY;

endmodule
